mem_dump_reader: RTL and testbench
==================================

Name: mem_dump_reader

Overview:
Read-side counterpart to the data-BRAM loader. On a start pulse it walks a word-aligned address range of the data BRAM through the bram32 debug read port. It emits each word on a valid/ready stream toward a host or UART transmitter and accumulates a 32-bit checksum. It sits beside D_MEM and replaces per-address hierarchical checks with post-run memory readback.

Parameters:
ADDR_WIDTH, 10, byte-address width of the bram32 debug port
DATA_WIDTH, 32, word width (matches `DATA_WIDTH)
CNT_WIDTH, 9, width of the word-count request (max 2^CNT_WIDTH-1 words)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
start  input  1  single-cycle request; sampled only in IDLE
base_addr  input  ADDR_WIDTH  first byte address; bits [1:0] ignored (forced 0)
word_count  input  CNT_WIDTH  number of words to dump
debug_addr  output  ADDR_WIDTH  registered address to bram32 debug port
debug_data  input  DATA_WIDTH  combinational read data from bram32 debug port
m_valid  output  1  stream word valid
m_ready  input  1  downstream accepts word
m_data  output  DATA_WIDTH  stream word
m_last  output  1  high with final word of the dump
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse at end of dump
checksum  output  DATA_WIDTH  mod-2^32 sum of all words sent in the current dump

Behaviour:
- Reset (rst=0, async): state=IDLE. debug_addr=0, m_valid=0, m_data=0, m_last=0, busy=0, done=0, checksum=0, internal addr/remaining=0.
- FSM states: IDLE, FETCH, SEND, DONE.
- IDLE:
  - start=1 and word_count!=0: latch cur_addr={base_addr[ADDR_WIDTH-1:2],2'b00}, remaining=word_count; clear checksum; go FETCH.
  - start=1 and word_count==0: checksum cleared; go DONE directly; no stream traffic.
- FETCH (1 cycle): debug_addr=cur_addr, registered on entry. debug_data is combinational, so at the end of FETCH m_data<=debug_data, m_valid<=1, m_last<=(remaining==1); go SEND.
- SEND:
  - m_data/m_last held stable while m_valid=1 and m_ready=0; no retraction.
  - On m_valid&&m_ready: checksum<=checksum+m_data (mod 2^32), m_valid<=0.
  - If remaining==1: m_last<=0; go DONE.
  - Else: cur_addr<=cur_addr+4, wrapping modulo 2^ADDR_WIDTH (0x3FC -> 0x000); remaining<=remaining-1; go FETCH.
- DONE: done=1 for exactly one cycle, then IDLE. checksum holds its final value until the next accepted start or reset.
- Throughput: max one word per 2 cycles. Latency start -> first m_valid = 2 cycles.
- start while busy: ignored, no latching.
- base_addr/word_count sampled only on the accepted start; later changes have no effect.
- m_ready high while m_valid low: no effect.
- Reset mid-dump: immediate return to IDLE, all outputs to reset values; the partial dump is abandoned.

Decomposition:
- Shared header rv32i_params.vh: FSM state encodings (DUMP_IDLE, DUMP_FETCH, DUMP_SEND, DUMP_DONE, 2-bit) and the word stride constant (4). DATA_WIDTH is already present.
- No sub-module: FSM, address/count registers and checksum adder live in one module.
- Benches instantiate it with bram32 D_MEM's debug port.

Test Plan:
- Preload mem[0x0]=0x1, mem[0x4]=0x2, mem[0xC]=0x3. Start, base=0x0, count=4, m_ready=1 -> words 1,2,0,3; m_last on 4th only; done pulse after it; checksum=0x6.
- Same dump with m_ready low for 3 cycles on word 2 -> m_data=0x2 and m_valid held stable; sequence and checksum unchanged.
- base=0x3FC, count=2, mem[0x3FC]=0xAAAA0000, mem[0x0]=0x5555 -> debug_addr 0x3FC then 0x000; checksum=0xAAAA5555.
- count=0 -> done one cycle later, m_valid never asserted, checksum=0.
- base=0x7 (unaligned), count=1 -> debug_addr=0x4; start pulsed again mid-dump -> ignored, only one word emitted.
- Assert rst=0 while in SEND -> m_valid, busy, checksum and debug_addr go to 0 asynchronously; a new start after release runs a clean dump.

Source files
------------

// File: rtl/mem_dump_reader_pkg.sv
// mem_dump_reader_pkg: FSM encodings and the word stride shared by the dump reader
package mem_dump_reader_pkg;
   localparam logic [1:0] DUMP_IDLE  = 2'd0;
   localparam logic [1:0] DUMP_FETCH = 2'd1;
   localparam logic [1:0] DUMP_SEND  = 2'd2;
   localparam logic [1:0] DUMP_DONE  = 2'd3;
   localparam int WORD_STRIDE = 4;
endpackage

// File: rtl/mem_dump_reader_if.sv
// mem_dump_reader_if: valid/ready word stream from the dump reader toward a host
interface mem_dump_reader_if #(parameter int DATA_WIDTH = 32);
   logic                  valid;
   logic                  ready;
   logic                  last;
   logic [DATA_WIDTH-1:0] data;
   modport master(output valid, data, last, input ready);
   modport slave(input valid, data, last, output ready);
endinterface

// File: rtl/mem_dump_reader.sv
// mem_dump_reader: walks a word range of the data BRAM debug port, streams each word and sums them
module mem_dump_reader
   import mem_dump_reader_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 9
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [CNT_WIDTH-1:0]  word_count,
   output logic [ADDR_WIDTH-1:0] debug_addr,
   input  logic [DATA_WIDTH-1:0] debug_data,
   mem_dump_reader_if.master     m,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] checksum
);
   logic [1:0]            state;
   logic [ADDR_WIDTH-1:0] addr;
   logic [CNT_WIDTH-1:0]  remaining;

   // the address register drives the debug port directly, so it is registered on FETCH entry
   assign debug_addr = addr;
   assign busy       = state != DUMP_IDLE;
   assign done       = state == DUMP_DONE;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= DUMP_IDLE;
         addr      <= '0;
         remaining <= '0;
         m.valid   <= 1'b0;
         m.data    <= '0;
         m.last    <= 1'b0;
         checksum  <= '0;
      end else begin
         case (state)
            DUMP_IDLE: if (start) begin
               checksum <= '0;
               if (word_count != '0) begin
                  addr      <= {base_addr[ADDR_WIDTH-1:2], 2'b00};
                  remaining <= word_count;
               end
               state <= (word_count == '0) ? DUMP_DONE : DUMP_FETCH;
            end
            DUMP_FETCH: begin
               m.data  <= debug_data;
               m.valid <= 1'b1;
               m.last  <= remaining == CNT_WIDTH'(1);
               state   <= DUMP_SEND;
            end
            DUMP_SEND: if (m.valid && m.ready) begin
               checksum <= checksum + m.data;
               m.valid  <= 1'b0;
               if (remaining == CNT_WIDTH'(1)) begin
                  m.last <= 1'b0;
                  state  <= DUMP_DONE;
               end else begin
                  addr      <= addr + ADDR_WIDTH'(WORD_STRIDE);
                  remaining <= remaining - CNT_WIDTH'(1);
                  state     <= DUMP_FETCH;
               end
            end
            default: state <= DUMP_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_dump_reader.sv
// tb_mem_dump_reader: directed and randomized dumps checked against a word-list model of the memory
module tb_mem_dump_reader;
   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [9:0]  base_addr;
   logic [8:0]  word_count;
   logic [9:0]  debug_addr;
   logic [31:0] debug_data;
   logic        busy, done;
   logic [31:0] checksum;
   logic [31:0] mem [256];
   int          vectors = 0;
   int          errs = 0;

   mem_dump_reader_if #(.DATA_WIDTH(32)) m ();

   mem_dump_reader #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .CNT_WIDTH(9)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_count(word_count),
      .debug_addr(debug_addr), .debug_data(debug_data), .m(m),
      .busy(busy), .done(done), .checksum(checksum)
   );

   assign debug_data = mem[debug_addr[9:2]];

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // expected stream = memory words at consecutive aligned addresses, wrapping at the top
   task automatic run_dump(input logic [9:0] base, input int cnt, input int rdy_pct,
                           input int stall_at, input bit mid_start);
      logic [31:0] exp_q[$];
      logic [31:0] sum;
      logic [9:0]  a0;
      logic [7:0]  wi;
      int          n, stall, bound;
      bit          seen, holding;
      a0 = {base[9:2], 2'b00};
      sum = 0; n = 0; stall = 0; seen = 0; holding = 0;
      bound = 12 * cnt + 20;
      for (int i = 0; i < cnt; i++) begin
         wi = 8'(int'(a0[9:2]) + i);
         exp_q.push_back(mem[wi]);
         sum = sum + mem[wi];
      end
      start = 1'b1; base_addr = base; word_count = 9'(cnt);
      @(negedge clk);
      start = 1'b0; base_addr = 10'($urandom); word_count = 9'($urandom);
      if (cnt == 0) chk("zero_done_latency", done, 1);
      for (int c = 0; c < bound && !seen; c++) begin
         start = mid_start && c == 1;
         if (done) begin
            seen = 1;
            chk("word_count", n, cnt);
            chk("checksum", checksum, sum);
            chk("valid_at_done", m.valid, 0);
         end else begin
            chk("busy", busy, 1);
            if (holding) chk("retract", m.valid, 1);
            if (c == 1) chk("first_valid", m.valid, 1);
            if (m.valid) begin
               if (n < cnt) begin
                  chk("data", m.data, exp_q[n]);
                  chk("last", m.last, 32'(n == cnt - 1));
               end else chk("extra_word", m.valid, 0);
               if (stall_at == n && stall < 3) begin
                  m.ready = 1'b0;
                  stall++;
               end else m.ready = $urandom_range(99) < rdy_pct;
               holding = !m.ready;
               if (m.ready) n++;
            end else begin
               chk("debug_addr", debug_addr, 32'(10'(a0 + 10'(4 * n))));
               m.ready = 1'($urandom_range(1));
            end
         end
         @(negedge clk);
      end
      start = 1'b0;
      chk("done_seen", seen, 1);
      chk("done_pulse", done, 0);
      chk("idle", busy, 0);
      chk("checksum_hold", checksum, sum);
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; base_addr = '0; word_count = '0; m.ready = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = '0;
      @(negedge clk);
      chk("rst_valid", m.valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_addr", debug_addr, 0);
      chk("rst_checksum", checksum, 0);
      rst = 1'b1;
      @(negedge clk);
      mem[0] = 32'h1; mem[1] = 32'h2; mem[3] = 32'h3;
      run_dump(10'h000, 4, 100, -1, 0);
      chk("basic_sum", checksum, 32'h6);
      run_dump(10'h000, 4, 100, 1, 0);
      chk("stall_sum", checksum, 32'h6);
      mem[255] = 32'hAAAA0000; mem[0] = 32'h5555;
      run_dump(10'h3FC, 2, 100, -1, 0);
      chk("wrap_sum", checksum, 32'hAAAA5555);
      run_dump(10'h000, 0, 100, -1, 0);
      chk("zero_sum", checksum, 0);
      mem[1] = 32'hC0FFEE;
      run_dump(10'h007, 1, 100, -1, 1);
      chk("unaligned_sum", checksum, 32'hC0FFEE);
      mem[4] = 32'h1234; mem[5] = 32'h5678;
      start = 1'b1; base_addr = 10'h010; word_count = 9'd3; m.ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("pre_rst_sum", checksum, 32'h1234);
      m.ready = 1'b0;
      @(negedge clk);
      chk("pre_rst_valid", m.valid, 1);
      #2 rst = 1'b0;
      #1;
      chk("async_valid", m.valid, 0);
      chk("async_busy", busy, 0);
      chk("async_checksum", checksum, 0);
      chk("async_addr", debug_addr, 0);
      chk("async_data", m.data, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      run_dump(10'h010, 3, 100, -1, 0);
      for (int t = 0; t < 16; t++) begin
         for (int i = 0; i < 256; i++) mem[i] = $urandom;
         run_dump(10'($urandom_range(1023)), $urandom_range(40), $urandom_range(100, 50),
                  $urandom_range(3) == 0 ? int'($urandom_range(5)) : -1, 1'($urandom_range(1)));
      end
      run_dump(10'($urandom_range(1023)), 511, 100, -1, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
